// File: rtl/ssd1306_spi_responder.sv
// ssd1306_spi_responder
//
// Receive-only model of the SSD1306 end of an OLED SPI link. The serial
// stream is oversampled on the system clock: every pin goes through a
// 2-flop synchronizer, and a third flop on spi_clk detects its rising edge.
// Completed bytes are decoded. Command bytes (dc_n=0) drive a small
// OPCODE/ARG1/ARG2 FSM that updates the configuration registers. Data bytes
// (dc_n=1) are written into a GDDRAM mirror, and the SSD1306 address then
// auto-increments. Other logic can read the mirror through a registered,
// read-first port.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   oled_spi_clk/_data    serial clock (rising-edge sampled, MSB first) / data
//   oled_dc_n             0 = command, 1 = data; sampled with bit 0
//   oled_reset_n          active-low display reset (configuration only)
//   oled_vdd, oled_vbat   active-low supplies; bytes are dropped while vdd=1
//   rd_addr / rd_data     {page, col} GDDRAM readback, one cycle latency
//   byte_strobe, rx_byte, rx_dc   one pulse and contents per accepted byte
//   display_on .. com_pins        decoded configuration
//   cur_page, cur_col             current write pointer
//   panel_active          display on, charge pump on, both supplies on
//   err_timeout           pulse when a partial byte is discarded
//
// Build option: define SSD_RX_FRAME_TIMEOUT_EN to discard a partial byte
// after TIMEOUT idle cycles. When it is undefined, a partial byte is held
// indefinitely and err_timeout is tied low.

module ssd1306_spi_responder #(
  parameter int  PAGES   = 4,
  parameter int  COLS    = 128,
  parameter int  TIMEOUT = 64,
  localparam int PW      = $clog2(PAGES),
  localparam int CW      = $clog2(COLS),
  localparam int AW      = PW + CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          oled_spi_clk,
  input  logic          oled_spi_data,
  input  logic          oled_dc_n,
  input  logic          oled_reset_n,
  input  logic          oled_vdd,
  input  logic          oled_vbat,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          byte_strobe,
  output logic [7:0]    rx_byte,
  output logic          rx_dc,
  output logic          display_on,
  output logic          charge_pump,
  output logic          seg_remap,
  output logic          com_scan,
  output logic [7:0]    contrast,
  output logic [7:0]    precharge,
  output logic [7:0]    com_pins,
  output logic [PW-1:0] cur_page,
  output logic [CW-1:0] cur_col,
  output logic          panel_active,
  output logic          err_timeout
);

  typedef enum logic [1:0] {ST_OPCODE, ST_ARG1, ST_ARG2} state_t;

  // Synchronizers. The supplies reset to "off" so that nothing is accepted
  // before the pins have been sampled.
  logic [2:0] sclk_q;
  logic [1:0] sdat_q, sdc_q, srst_q, svdd_q, svbat_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_q  <= '0;
      sdat_q  <= '0;
      sdc_q   <= '0;
      srst_q  <= '0;
      svdd_q  <= 2'b11;
      svbat_q <= 2'b11;
    end else begin
      sclk_q  <= {sclk_q[1:0], oled_spi_clk};
      sdat_q  <= {sdat_q[0], oled_spi_data};
      sdc_q   <= {sdc_q[0], oled_dc_n};
      srst_q  <= {srst_q[0], oled_reset_n};
      svdd_q  <= {svdd_q[0], oled_vdd};
      svbat_q <= {svbat_q[0], oled_vbat};
    end
  end

  logic spi_rise, dat_s, dc_s, rstn_s, vdd_s, vbat_s;
  assign spi_rise = sclk_q[1] & ~sclk_q[2];
  assign dat_s    = sdat_q[1];
  assign dc_s     = sdc_q[1];
  assign rstn_s   = srst_q[1];
  assign vdd_s    = svdd_q[1];
  assign vbat_s   = svbat_q[1];

  // Bit assembly: one edge after the rise is seen, the completed byte is
  // presented to the decoder as a single-cycle done_q.
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] shift_d;
  logic       done_q;
  logic [7:0] done_byte_q;
  logic       done_dc_q;

  assign shift_d = {shift_q, dat_s};

`ifdef SSD_RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;
  logic          err_timeout_q;
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset || !rstn_s) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      done_q        <= 1'b0;
      done_byte_q   <= '0;
      done_dc_q     <= 1'b0;
`ifdef SSD_RX_FRAME_TIMEOUT_EN
      idle_q        <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (spi_rise) begin
        shift_q <= shift_d[6:0];
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_q   <= '0;
          done_q      <= 1'b1;
          done_byte_q <= shift_d;
          done_dc_q   <= dc_s;
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end
`ifdef SSD_RX_FRAME_TIMEOUT_EN
      // A rise always wins over the timeout, so the idle count only expires
      // while no new bit is arriving.
      err_timeout_q <= 1'b0;
      if (spi_rise || bit_cnt_q == 3'd0) begin
        idle_q <= '0;
      end else if (idle_q == TW'(TIMEOUT - 1)) begin
        idle_q        <= '0;
        bit_cnt_q     <= '0;
        err_timeout_q <= 1'b1;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
`endif
    end
  end

  // A byte is accepted only while the logic supply is on and the display is
  // out of reset.
  logic acc;
  assign acc = done_q & ~vdd_s & rstn_s;

  logic       byte_strobe_q;
  logic [7:0] rx_byte_q;
  logic       rx_dc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_strobe_q <= 1'b0;
      rx_byte_q     <= '0;
      rx_dc_q       <= 1'b0;
    end else begin
      byte_strobe_q <= acc;
      if (acc) begin
        rx_byte_q <= done_byte_q;
        rx_dc_q   <= done_dc_q;
      end
    end
  end

  // Command decoder and address pointer
  state_t        state_q;
  logic [7:0]    op_q;
  logic [CW-1:0] pend_col_q;
  logic [PW-1:0] pend_page_q;
  logic          display_on_q, charge_pump_q, seg_remap_q, com_scan_q;
  logic [7:0]    contrast_q, precharge_q, com_pins_q;
  logic [1:0]    addr_mode_q;
  logic [PW-1:0] cur_page_q, page_start_q, page_end_q;
  logic [CW-1:0] cur_col_q, col_start_q, col_end_q;

  always_ff @(posedge clock) begin
    if (reset || !rstn_s) begin
      state_q       <= ST_OPCODE;
      op_q          <= '0;
      pend_col_q    <= '0;
      pend_page_q   <= '0;
      display_on_q  <= 1'b0;
      charge_pump_q <= 1'b0;
      seg_remap_q   <= 1'b0;
      com_scan_q    <= 1'b0;
      contrast_q    <= 8'h7F;
      precharge_q   <= 8'h22;
      com_pins_q    <= 8'h12;
      addr_mode_q   <= 2'b00;
      cur_page_q    <= '0;
      cur_col_q     <= '0;
      page_start_q  <= '0;
      page_end_q    <= PW'(PAGES - 1);
      col_start_q   <= '0;
      col_end_q     <= CW'(COLS - 1);
    end else if (acc) begin
      if (done_dc_q) begin
        // A data byte also cancels any half-received command.
        state_q <= ST_OPCODE;
        if (addr_mode_q == 2'b10) begin
          cur_col_q <= cur_col_q + 1'b1;
        end else if (cur_col_q == col_end_q) begin
          cur_col_q  <= col_start_q;
          cur_page_q <= (cur_page_q == page_end_q) ? page_start_q : cur_page_q + 1'b1;
        end else begin
          cur_col_q <= cur_col_q + 1'b1;
        end
      end else begin
        unique case (state_q)
          ST_OPCODE: begin
            op_q <= done_byte_q;
            casez (done_byte_q)
              8'hAE:        display_on_q <= 1'b0;
              8'hAF:        display_on_q <= 1'b1;
              8'hA0:        seg_remap_q  <= 1'b0;
              8'hA1:        seg_remap_q  <= 1'b1;
              8'hC0:        com_scan_q   <= 1'b0;
              8'hC8:        com_scan_q   <= 1'b1;
              8'b0000_????: cur_col_q[3:0] <= done_byte_q[3:0];
              8'b0001_????: cur_col_q  <= CW'({done_byte_q[3:0], cur_col_q[3:0]});
              8'b1011_0???: cur_page_q <= done_byte_q[PW-1:0];
              8'h81, 8'h8D, 8'hD9, 8'hDA,
              8'h20, 8'h21, 8'h22: state_q <= ST_ARG1;
              default: ;
            endcase
          end
          ST_ARG1: begin
            state_q <= ST_OPCODE;
            case (op_q)
              8'h81: contrast_q    <= done_byte_q;
              8'h8D: charge_pump_q <= done_byte_q[2];
              8'hD9: precharge_q   <= done_byte_q;
              8'hDA: com_pins_q    <= done_byte_q;
              8'h20: addr_mode_q   <= done_byte_q[1:0];
              8'h21: begin
                pend_col_q <= done_byte_q[CW-1:0];
                state_q    <= ST_ARG2;
              end
              8'h22: begin
                pend_page_q <= done_byte_q[PW-1:0];
                state_q     <= ST_ARG2;
              end
              default: ;
            endcase
          end
          default: begin
            // Range commands commit only when both arguments have arrived.
            state_q <= ST_OPCODE;
            if (op_q == 8'h21) begin
              col_start_q <= pend_col_q;
              col_end_q   <= done_byte_q[CW-1:0];
              cur_col_q   <= pend_col_q;
            end else begin
              page_start_q <= pend_page_q;
              page_end_q   <= done_byte_q[PW-1:0];
              cur_page_q   <= pend_page_q;
            end
          end
        endcase
      end
    end
  end

  // GDDRAM mirror: contents survive both resets. The read is read-first.
  logic [7:0] gddram [PAGES*COLS];
  logic [7:0] rd_data_q;
  logic       wr_en;
  assign wr_en = acc & done_dc_q;

  always_ff @(posedge clock) begin
    if (wr_en) gddram[{cur_page_q, cur_col_q}] <= done_byte_q;
  end

  always_ff @(posedge clock) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= gddram[rd_addr];
  end

  assign rd_data      = rd_data_q;
  assign byte_strobe  = byte_strobe_q;
  assign rx_byte      = rx_byte_q;
  assign rx_dc        = rx_dc_q;
  assign display_on   = display_on_q;
  assign charge_pump  = charge_pump_q;
  assign seg_remap    = seg_remap_q;
  assign com_scan     = com_scan_q;
  assign contrast     = contrast_q;
  assign precharge    = precharge_q;
  assign com_pins     = com_pins_q;
  assign cur_page     = cur_page_q;
  assign cur_col      = cur_col_q;
  assign panel_active = display_on_q & charge_pump_q & ~vbat_s & ~vdd_s;

endmodule

// File: tb/tb_ssd1306_spi_responder.sv
module tb_ssd1306_spi_responder;

  logic       clock = 0;
  logic       reset = 1;
  logic       oled_spi_clk = 0, oled_spi_data = 0, oled_dc_n = 0;
  logic       oled_reset_n = 1, oled_vdd = 0, oled_vbat = 1;
  logic [8:0] rd_addr = '0;
  logic [7:0] rd_data, rx_byte, contrast, precharge, com_pins;
  logic       byte_strobe, rx_dc, display_on, charge_pump, seg_remap, com_scan;
  logic [1:0] cur_page;
  logic [6:0] cur_col;
  logic       panel_active, err_timeout;

  ssd1306_spi_responder dut (
    .clock(clock), .reset(reset),
    .oled_spi_clk(oled_spi_clk), .oled_spi_data(oled_spi_data),
    .oled_dc_n(oled_dc_n), .oled_reset_n(oled_reset_n),
    .oled_vdd(oled_vdd), .oled_vbat(oled_vbat),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_strobe(byte_strobe), .rx_byte(rx_byte), .rx_dc(rx_dc),
    .display_on(display_on), .charge_pump(charge_pump),
    .seg_remap(seg_remap), .com_scan(com_scan),
    .contrast(contrast), .precharge(precharge), .com_pins(com_pins),
    .cur_page(cur_page), .cur_col(cur_col),
    .panel_active(panel_active), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc++;

  int tests = 0, fails = 0;
  int strobes = 0, err_seen = 0;

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural display model ----------------
  int         m_disp, m_cp, m_seg, m_com, m_con, m_pre, m_pins, m_mode;
  int         m_page, m_col, m_pstart, m_pend, m_cstart, m_cend;
  int         m_op;          // pending opcode awaiting arguments, -1 if none
  int         m_args[$];
  logic [7:0] m_mem [512];
  bit         m_wr  [512];

  function automatic void model_reset();
    m_disp = 0; m_cp = 0; m_seg = 0; m_com = 0;
    m_con = 'h7F; m_pre = 'h22; m_pins = 'h12; m_mode = 0;
    m_page = 0; m_col = 0; m_pstart = 0; m_pend = 3; m_cstart = 0; m_cend = 127;
    m_op = -1; m_args.delete();
  endfunction

  function automatic void model_byte(int b, bit dc);
    int need, idx;
    if (dc) begin
      m_op = -1; m_args.delete();
      idx = m_page * 128 + m_col;
      m_mem[idx] = 8'(b); m_wr[idx] = 1;
      if (m_mode == 2) m_col = (m_col + 1) % 128;
      else if (m_col == m_cend) begin
        m_col  = m_cstart;
        m_page = (m_page == m_pend) ? m_pstart : (m_page + 1) % 4;
      end else m_col = (m_col + 1) % 128;
    end else if (m_op < 0) begin
      if      (b == 'hAE) m_disp = 0;
      else if (b == 'hAF) m_disp = 1;
      else if (b == 'hA0) m_seg = 0;
      else if (b == 'hA1) m_seg = 1;
      else if (b == 'hC0) m_com = 0;
      else if (b == 'hC8) m_com = 1;
      else if (b < 16)    m_col = (m_col / 16) * 16 + b;
      else if (b < 32)    m_col = ((b % 16) * 16 + m_col % 16) % 128;
      else if (b >= 'hB0 && b <= 'hB7) m_page = b % 4;
      else if (b inside {'h81, 'h8D, 'hD9, 'hDA, 'h20, 'h21, 'h22}) m_op = b;
    end else begin
      m_args.push_back(b);
      need = (m_op == 'h21 || m_op == 'h22) ? 2 : 1;
      if (m_args.size() == need) begin
        case (m_op)
          'h81: m_con  = m_args[0];
          'h8D: m_cp   = (m_args[0] / 4) % 2;
          'hD9: m_pre  = m_args[0];
          'hDA: m_pins = m_args[0];
          'h20: m_mode = m_args[0] % 4;
          'h21: begin m_cstart = m_args[0] % 128; m_cend = m_args[1] % 128; m_col = m_cstart; end
          default: begin m_pstart = m_args[0] % 4; m_pend = m_args[1] % 4; m_page = m_pstart; end
        endcase
        m_op = -1; m_args.delete();
      end
    end
  endfunction

  typedef struct {
    int b; int dc; int disp; int cp; int seg; int com;
    int con; int pre; int pins; int page; int col; longint cyc;
  } snap_t;
  snap_t exp_q[$];

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (err_timeout) err_seen++;
      if (byte_strobe) begin
        strobes++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_strobe: got rx_byte %0h, expected no strobe", rx_byte);
        end else begin
          snap_t s;
          s = exp_q.pop_front();
          chk("strobe_latency", cyc, s.cyc);
          chk("rx_byte", rx_byte, s.b);
          chk("rx_dc", rx_dc, s.dc);
          chk("display_on", display_on, s.disp);
          chk("charge_pump", charge_pump, s.cp);
          chk("seg_remap", seg_remap, s.seg);
          chk("com_scan", com_scan, s.com);
          chk("contrast", contrast, s.con);
          chk("precharge", precharge, s.pre);
          chk("com_pins", com_pins, s.pins);
          chk("cur_page", cur_page, s.page);
          chk("cur_col", cur_col, s.col);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic spi_bit(input bit v, input bit dc);
    @(negedge clock);
    oled_spi_clk = 0; oled_spi_data = v; oled_dc_n = dc;
    repeat (4) @(negedge clock);
    oled_spi_clk = 1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit dc, input int n);
    for (int i = 0; i < n; i++) begin
      spi_bit(b[7-i], dc);
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dc);
    snap_t s;
    send_bits(b, dc, 7);
    spi_bit(b[0], dc);
    // Capture edge is the next posedge; the strobe follows three edges later.
    if (oled_vdd == 0 && oled_reset_n == 1) begin
      model_byte(b, dc);
      s.b = b; s.dc = dc; s.disp = m_disp; s.cp = m_cp; s.seg = m_seg; s.com = m_com;
      s.con = m_con; s.pre = m_pre; s.pins = m_pins; s.page = m_page; s.col = m_col;
      s.cyc = cyc + 4;
      exp_q.push_back(s);
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge clock);
      chk("strobe_timeout", exp_q.size(), 0);
      exp_q.delete();
    end else begin
      repeat (8) @(negedge clock);
    end
  endtask

  task automatic oled_rst();
    @(negedge clock);
    oled_reset_n = 0;
    repeat (6) @(negedge clock);
    oled_reset_n = 1;
    repeat (4) @(negedge clock);
    model_reset();
  endtask

  task automatic rd_at(input int p, input int c);
    @(negedge clock);
    rd_addr = 9'(p * 128 + c);
    @(negedge clock);
  endtask

  task automatic rd_check(input int p, input int c);
    rd_at(p, c);
    if (m_wr[p * 128 + c]) chk("rd_data", rd_data, m_mem[p * 128 + c]);
  endtask

  logic [7:0] init_seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                8'hFF, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
  logic [7:0] cmds [20] = '{8'hAE, 8'hAF, 8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'h03, 8'h1A,
                            8'hB2, 8'hB5, 8'h81, 8'h8D, 8'hD9, 8'hDA, 8'h20, 8'h21,
                            8'h22, 8'h12, 8'h0F, 8'hB7};

  initial begin
    int s0, e0, p, c;
    logic [7:0] b;
    bit dc;
    model_reset();
    for (int i = 0; i < 512; i++) m_wr[i] = 0;

    // Reset values, sampled while reset is still asserted
    repeat (4) @(negedge clock);
    chk("rst_display_on", display_on, 0);
    chk("rst_charge_pump", charge_pump, 0);
    chk("rst_seg_remap", seg_remap, 0);
    chk("rst_com_scan", com_scan, 0);
    chk("rst_contrast", contrast, 8'h7F);
    chk("rst_precharge", precharge, 8'h22);
    chk("rst_com_pins", com_pins, 8'h12);
    chk("rst_cur_page", cur_page, 0);
    chk("rst_cur_col", cur_col, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_rx_dc", rx_dc, 0);
    chk("rst_byte_strobe", byte_strobe, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_panel_active", panel_active, 0);
    reset = 0;
    repeat (4) @(negedge clock);

    // Init sequence
    foreach (init_seq[i]) send_byte(init_seq[i], 0);
    oled_vbat = 0;
    repeat (4) @(negedge clock);
    chk("init_display_on", display_on, 1);
    chk("init_charge_pump", charge_pump, 1);
    chk("init_precharge", precharge, 8'hF1);
    chk("init_contrast", contrast, 8'hFF);
    chk("init_com_pins", com_pins, 8'h00);
    chk("init_panel_active", panel_active, 1);
    chk("init_strobes", strobes, 12);

    // Addressing: page range 1..2, column 0, then 130 data bytes
    send_byte(8'h22, 0); send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    for (int i = 0; i < 130; i++) send_byte(8'(i), 1);
    rd_at(1, 5);
    chk("addr_rd_1_5", rd_data, 8'h05);
    rd_at(2, 1);
    chk("addr_rd_2_1", rd_data, 8'h81);
    chk("addr_cur_page", cur_page, 2);
    chk("addr_cur_col", cur_col, 2);

    // Argument abort, starting from a freshly reset display
    oled_rst();
    send_byte(8'h81, 0);
    send_byte(8'h55, 1);
    chk("abort_contrast", contrast, 8'h7F);
    rd_at(0, 0);
    chk("abort_rd_0_0", rd_data, 8'h55);

    // Mid-byte display reset
    send_byte(8'h81, 0); send_byte(8'h40, 0); send_byte(8'h05, 0);
    chk("mid_contrast_set", contrast, 8'h40);
    chk("mid_col_set", cur_col, 5);
    send_bits(8'hC3, 1, 3);
    oled_rst();
    chk("mid_contrast", contrast, 8'h7F);
    chk("mid_cur_col", cur_col, 0);
    send_byte(8'hA5, 1);
    chk("mid_rx_byte", rx_byte, 8'hA5);
    rd_at(0, 0);
    chk("mid_rd_0_0", rd_data, 8'hA5);
    rd_at(1, 5);
    chk("mid_retained", rd_data, 8'h05);

    // Power off: a byte sent with vdd high is dropped
    oled_vdd = 1;
    repeat (4) @(negedge clock);
    s0 = strobes;
    send_byte(8'hAF, 0);
    repeat (6) @(negedge clock);
    chk("pwr_no_strobe", strobes, s0);
    chk("pwr_display_on", display_on, 0);
    oled_vdd = 0;
    repeat (4) @(negedge clock);

    // Partial byte followed by a long idle gap
    e0 = err_seen;
    send_bits(8'h3C, 1, 5);
    repeat (90) @(negedge clock);
`ifdef SSD_RX_FRAME_TIMEOUT_EN
    chk("timeout_pulses", err_seen - e0, 1);
`else
    chk("timeout_pulses", err_seen - e0, 0);
    oled_rst();
`endif
    send_byte(8'h3C, 1);
    chk("timeout_rx_byte", rx_byte, 8'h3C);

    // Randomized traffic against the model
    for (int n = 0; n < 260; n++) begin
      dc = $urandom_range(0, 1);
      if (!dc && $urandom_range(0, 3) != 0) b = cmds[$urandom_range(0, 19)];
      else b = 8'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        oled_vdd = 1;
        repeat (4) @(negedge clock);
        s0 = strobes;
        send_byte(b, dc);
        repeat (4) @(negedge clock);
        chk("rand_pwr_drop", strobes, s0);
        oled_vdd = 0;
        repeat (4) @(negedge clock);
      end else if ($urandom_range(0, 59) == 0) begin
        oled_rst();
      end else begin
        send_byte(b, dc);
      end
      if (n % 16 == 15) rd_check(m_page, (m_col + 127) % 128);
    end
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 3);
      c = $urandom_range(0, 127);
      rd_check(p, c);
    end

`ifndef SSD_RX_FRAME_TIMEOUT_EN
    chk("no_err_timeout", err_seen, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
